uart_port_arbiter: RTL

Two-master round-robin arbiter that shares the single memory-mapped UART slave port (control/status at offset 0x0, RX data at 0x4, TX data at 0x8) between the CPU core data bus (master 0) and the debug/boot-loader bus (master 1). It sits between the core's peripheral interconnect and the UART. It serialises whole transactions, routes read data and ready back to the owning master, and recovers from a hung slave with a bounded timeout.

---
 rtl/uart_pkg.sv | 16 +
 rtl/rr_arb2.sv | 19 +
 rtl/uart_port_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART slave port and its bus arbiter.
// Register offsets, arbiter states and the timeout read value.
package uart_pkg;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_e;

   localparam logic [3:0] UART_CTRL   = 4'h0;
   localparam logic [3:0] UART_RXDATA = 4'h4;
   localparam logic [3:0] UART_TXDATA = 4'h8;

   localparam logic [31:0] UART_ERR_RDATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin pick; the most recent grantee loses a tie.
// Pure combinational, reused by other shared-peripheral ports.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic       gnt_idx
);

   always_comb begin
      gnt_idx = 1'b0;
      unique case (req)
         2'b01:   gnt_idx = 1'b0;
         2'b10:   gnt_idx = 1'b1;
         2'b11:   gnt_idx = ~last;
         default: gnt_idx = 1'b0;
      endcase
   end

endmodule

// File: rtl/uart_port_arbiter.sv
// Shares the UART slave port between the core data bus (m0) and the
// debug/boot-loader bus (m1), one whole transaction at a time.
module uart_port_arbiter
   import uart_pkg::*;
#(
   parameter int unsigned STRB_W         = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter logic [31:0] ERR_RDATA      = UART_ERR_RDATA
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              m0_valid,
   output logic              m0_ready,
   input  logic [31:0]       m0_addr,
   input  logic [31:0]       m0_wdata,
   input  logic [STRB_W-1:0] m0_wstrb,
   output logic [31:0]       m0_rdata,
   input  logic              m1_valid,
   output logic              m1_ready,
   input  logic [31:0]       m1_addr,
   input  logic [31:0]       m1_wdata,
   input  logic [STRB_W-1:0] m1_wstrb,
   output logic [31:0]       m1_rdata,
   output logic              s_valid,
   input  logic              s_ready,
   output logic [31:0]       s_addr,
   output logic [31:0]       s_wdata,
   output logic [STRB_W-1:0] s_wstrb,
   input  logic [31:0]       s_rdata,
   output logic              owner,
   output logic              busy,
   output logic              err_timeout
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   arb_state_e       state_q, state_d;
   logic             owner_q, owner_d;
   logic             last_q, last_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;

   logic             gnt_idx;
   logic             in_busy;
   logic             own_valid;
   logic             done;
   logic             tmo;
   logic             rsp_ready;
   logic [31:0]      rsp_data;

   rr_arb2 u_rr (
      .req     ({m1_valid, m0_valid}),
      .last    (last_q),
      .gnt_idx (gnt_idx)
   );

   assign in_busy   = (state_q == ARB_BUSY);
   assign own_valid = owner_q ? m1_valid : m0_valid;
   assign done      = in_busy && own_valid && s_ready;
   assign tmo       = in_busy && own_valid && !s_ready
                      && (cnt_q == CNT_LAST);

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      unique case (state_q)
         ARB_IDLE: begin
            if (m0_valid || m1_valid) begin
               state_d = ARB_BUSY;
               owner_d = gnt_idx;
               cnt_d   = '0;
            end
         end
         ARB_BUSY: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (done || tmo) begin
               state_d = ARB_IDLE;
               last_d  = owner_q;
            end else if (!own_valid) begin
               // master withdrew: no response, fairness history kept
               state_d = ARB_IDLE;
            end
            if (tmo) err_d = 1'b1;
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= ARB_IDLE;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      s_valid   = 1'b0;
      s_addr    = '0;
      s_wdata   = '0;
      s_wstrb   = '0;
      rsp_ready = 1'b0;
      rsp_data  = '0;
      if (in_busy) begin
         s_valid   = own_valid && !tmo;
         s_addr    = owner_q ? m1_addr  : m0_addr;
         s_wdata   = owner_q ? m1_wdata : m0_wdata;
         s_wstrb   = owner_q ? m1_wstrb : m0_wstrb;
         rsp_ready = done || tmo;
         rsp_data  = tmo ? ERR_RDATA : s_rdata;
      end
   end

   always_comb begin
      m0_ready = 1'b0;
      m1_ready = 1'b0;
      m0_rdata = '0;
      m1_rdata = '0;
      if (rsp_ready) begin
         if (owner_q) begin
            m1_ready = 1'b1;
            m1_rdata = rsp_data;
         end else begin
            m0_ready = 1'b1;
            m0_rdata = rsp_data;
         end
      end
   end

   assign owner       = owner_q;
   assign busy        = in_busy;
   assign err_timeout = err_q;

endmodule
